// File: rtl/mask_load_ctrl_if.sv
// ==== mask_load_ctrl_if : command, readback and serial-drive bundle (rev 1.0) ====
`default_nettype none

interface mask_load_ctrl_if #(
  parameter int LEN = 64
);
  logic           Start;
  logic           Clear;
  logic [LEN-1:0] Data;
  logic [LEN-1:0] Po;
  logic           Load;
  logic           Si;
  logic           ClrOut;
  logic           Busy;
  logic           Done;
  logic           Err;

  modport master (
    output Start, Clear, Data, Po,
    input  Load, Si, ClrOut, Busy, Done, Err
  );

  modport slave (
    input  Start, Clear, Data, Po,
    output Load, Si, ClrOut, Busy, Done, Err
  );
endinterface

`default_nettype wire

// File: rtl/mask_load_ctrl.sv
// ==== mask_load_ctrl : loads a SIPO mask register MSB-first and verifies it (rev 1.0) ====
`default_nettype none

module mask_load_ctrl #(
  parameter int LEN = 64,
  parameter int CW  = 7
) (
  input  wire logic       Clk,
  input  wire logic       Reset,
  mask_load_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [2:0]     state;
  logic [LEN-1:0] shadow;
  logic [CW-1:0]  cnt;
  logic           err;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      shadow <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Clear) begin
            shadow <= '0;
            err    <= 1'b0;
            state  <= CLEAR;
          end else if (bus.Start) begin
            shadow <= bus.Data;
            cnt    <= '0;
            err    <= 1'b0;
            state  <= SHIFT;
          end
        end
        CLEAR: state <= CHECK;
        SHIFT: begin
          // Rotating keeps the original value, so CHECK compares against Data itself.
          shadow <= {shadow[LEN-2:0], shadow[LEN-1]};
          cnt    <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          err   <= (bus.Po != shadow);
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so reset clears them without an edge.
  assign bus.Load   = (state == SHIFT);
  assign bus.Si     = (state == SHIFT) && shadow[LEN-1];
  assign bus.ClrOut = (state == CLEAR);
  assign bus.Busy   = (state == CLEAR) || (state == SHIFT) || (state == CHECK);
  assign bus.Done   = (state == DONE);
  assign bus.Err    = err;

endmodule

`default_nettype wire

// File: tb/tb_mask_load_ctrl.sv
// ==== tb_mask_load_ctrl : directed bench with a behavioural SIPO mask register (rev 1.0) ====
`default_nettype none

module tb_mask_load_ctrl;
  localparam int LEN = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mask_load_ctrl_if #(.LEN(LEN)) bus ();

  mask_load_ctrl #(.LEN(LEN), .CW(7)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  // Mask register model: not reset, cleared only by ClrOut.
  logic [LEN-1:0] sr;
  logic [LEN-1:0] stuck = '0;
  logic           preset_req = 1'b1;
  always @(posedge clk) begin
    if (preset_req)      sr <= '1;
    else if (bus.ClrOut) sr <= '0;
    else if (bus.Load)   sr <= {sr[LEN-2:0], bus.Si};
  end
  assign bus.Po = sr & ~stuck;

  int passed = 0;
  int total  = 0;

  int o_load, o_load_first, o_load_last, o_load_starts, o_load_start2;
  int o_si, o_si_first, o_si_last, o_clr, o_clr_first;
  int o_done, o_done_first, o_done_last, o_check_cyc, o_bad;
  logic [LEN-1:0] o_check_po;
  logic o_err_done, prev_load;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Records what happens over ncyc cycles; cycle 1 is the cycle after the accepting edge.
  task automatic observe(input int ncyc, input int pulse_cyc, input bit hold);
    o_load = 0; o_load_first = 0; o_load_last = 0; o_load_starts = 0; o_load_start2 = 0;
    o_si = 0; o_si_first = 0; o_si_last = 0; o_clr = 0; o_clr_first = 0;
    o_done = 0; o_done_first = 0; o_done_last = 0; o_check_cyc = 0; o_bad = 0;
    o_check_po = '0; o_err_done = 1'bx; prev_load = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (bus.Load) begin
        o_load++;
        if (o_load_first == 0) o_load_first = c;
        o_load_last = c;
        if (!prev_load) begin
          o_load_starts++;
          if (o_load_starts == 2) o_load_start2 = c;
        end
      end
      prev_load = bus.Load;
      if (bus.Si) begin
        o_si++;
        if (o_si_first == 0) o_si_first = c;
        o_si_last = c;
      end
      if (bus.ClrOut) begin
        o_clr++;
        if (o_clr_first == 0) o_clr_first = c;
      end
      if (bus.Done) begin
        o_done++;
        if (o_done_first == 0) o_done_first = c;
        o_done_last = c;
        o_err_done  = bus.Err;
      end
      if (bus.Busy && !bus.Load && !bus.ClrOut) begin
        o_check_cyc = c;
        o_check_po  = bus.Po;
      end
      if ((bus.Si && !bus.Load) || (bus.Load && bus.ClrOut) || (bus.Done && bus.Busy)) o_bad++;
      bus.Start = hold || (c == pulse_cyc);
      tick();
    end
  endtask

  task automatic test_reset;
    bus.Start = 1'b0; bus.Clear = 1'b0; bus.Data = '0;
    tick(); tick();
    preset_req = 1'b0;
    total++;
    if ({bus.Load, bus.Si, bus.ClrOut, bus.Busy, bus.Done, bus.Err} !== 6'b0)
      $display("FAIL reset_outputs: got %b expected 000000",
               {bus.Load, bus.Si, bus.ClrOut, bus.Busy, bus.Done, bus.Err});
    else passed++;
    rst_n = 1'b1;
    tick();
    total++;
    if ({bus.Load, bus.ClrOut, bus.Busy, bus.Done} !== 4'b0)
      $display("FAIL idle_after_reset: got %b expected 0000",
               {bus.Load, bus.ClrOut, bus.Busy, bus.Done});
    else passed++;
  endtask

  task automatic test_load;
    bus.Data  = 64'h8000_0000_0000_0001;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    observe(70, 0, 1'b0);
    total++; if (o_load !== 64) $display("FAIL load_cycles: got %0d expected 64", o_load); else passed++;
    total++; if (o_load_first !== 1 || o_load_last !== 64)
      $display("FAIL load_window: got %0d..%0d expected 1..64", o_load_first, o_load_last); else passed++;
    total++; if (o_si !== 2 || o_si_first !== 1 || o_si_last !== 64)
      $display("FAIL si_pattern: got n=%0d first=%0d last=%0d expected n=2 first=1 last=64",
               o_si, o_si_first, o_si_last); else passed++;
    total++; if (o_check_cyc !== 65) $display("FAIL load_check_cycle: got %0d expected 65", o_check_cyc); else passed++;
    total++; if (o_check_po !== 64'h8000_0000_0000_0001)
      $display("FAIL load_po: got %h expected 8000000000000001", o_check_po); else passed++;
    total++; if (o_done !== 1 || o_done_first !== 66)
      $display("FAIL load_done: got n=%0d at %0d expected n=1 at 66", o_done, o_done_first); else passed++;
    total++; if (o_err_done !== 1'b0) $display("FAIL load_err: got %b expected 0", o_err_done); else passed++;
    total++; if (o_bad !== 0 || o_clr !== 0)
      $display("FAIL load_exclusive: got bad=%0d clr=%0d expected 0 0", o_bad, o_clr); else passed++;
  endtask

  task automatic test_clear;
    preset_req = 1'b1;
    tick();
    preset_req = 1'b0;
    total++; if (bus.Po !== '1) $display("FAIL clear_preset: got %h expected all ones", bus.Po); else passed++;
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    observe(6, 0, 1'b0);
    total++; if (o_clr !== 1 || o_clr_first !== 1)
      $display("FAIL clrout: got n=%0d at %0d expected n=1 at 1", o_clr, o_clr_first); else passed++;
    total++; if (o_load !== 0) $display("FAIL clear_no_load: got %0d expected 0", o_load); else passed++;
    total++; if (o_check_cyc !== 2 || o_done_first !== 3)
      $display("FAIL clear_timing: got check=%0d done=%0d expected 2 3", o_check_cyc, o_done_first); else passed++;
    total++; if (o_err_done !== 1'b0 || bus.Po !== '0)
      $display("FAIL clear_result: got err=%b po=%h expected 0 0", o_err_done, bus.Po); else passed++;
  endtask

  task automatic test_stuck;
    stuck    = 64'h20;
    bus.Data = '1;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    observe(70, 0, 1'b0);
    total++; if (o_done_first !== 66 || o_err_done !== 1'b1)
      $display("FAIL stuck_err: got done=%0d err=%b expected 66 1", o_done_first, o_err_done); else passed++;
    total++; if (o_check_po !== 64'hFFFF_FFFF_FFFF_FFDF)
      $display("FAIL stuck_po: got %h expected ffffffffffffffdf", o_check_po); else passed++;
    repeat (5) tick();
    total++; if (bus.Err !== 1'b1 || bus.Busy !== 1'b0)
      $display("FAIL stuck_err_hold: got err=%b busy=%b expected 1 0", bus.Err, bus.Busy); else passed++;
    stuck     = '0;
    bus.Data  = 64'hA5A5_5A5A_0F0F_F0F0;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    total++; if (bus.Err !== 1'b0 || bus.Load !== 1'b1)
      $display("FAIL stuck_err_clear: got err=%b load=%b expected 0 1", bus.Err, bus.Load); else passed++;
    observe(70, 0, 1'b0);
    total++; if (o_done_first !== 66 || o_err_done !== 1'b0)
      $display("FAIL stuck_reload: got done=%0d err=%b expected 66 0", o_done_first, o_err_done); else passed++;
  endtask

  task automatic test_priority;
    bus.Start = 1'b1;
    bus.Clear = 1'b1;
    tick();
    bus.Start = 1'b0;
    bus.Clear = 1'b0;
    observe(8, 0, 1'b0);
    total++; if (o_clr !== 1 || o_load !== 0 || o_done !== 1 || o_done_first !== 3)
      $display("FAIL priority_clear: got clr=%0d load=%0d done=%0d at %0d expected 1 0 1 at 3",
               o_clr, o_load, o_done, o_done_first); else passed++;
    bus.Data  = 64'h0F0F_0F0F_0F0F_0F0F;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    observe(80, 10, 1'b0);
    total++; if (o_done !== 1 || o_load !== 64 || o_load_starts !== 1)
      $display("FAIL no_queue: got done=%0d load=%0d starts=%0d expected 1 64 1",
               o_done, o_load, o_load_starts); else passed++;
  endtask

  task automatic test_reset_mid_shift;
    bus.Data  = 64'hFFFF_FFFF_0000_0000;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    repeat (29) tick();
    total++; if ({bus.Load, bus.Si, bus.Busy} !== 3'b111)
      $display("FAIL pre_reset_shift: got %b expected 111", {bus.Load, bus.Si, bus.Busy}); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bus.Load, bus.Si, bus.Busy, bus.Done, bus.ClrOut} !== 5'b0)
      $display("FAIL async_reset: got %b expected 00000",
               {bus.Load, bus.Si, bus.Busy, bus.Done, bus.ClrOut}); else passed++;
    #2 rst_n = 1'b1;
    tick();
    bus.Data  = 64'h0123_4567_89AB_CDEF;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    observe(70, 0, 1'b0);
    total++; if (o_load !== 64 || o_done_first !== 66 || o_err_done !== 1'b0)
      $display("FAIL post_reset_load: got load=%0d done=%0d err=%b expected 64 66 0",
               o_load, o_done_first, o_err_done); else passed++;
    total++; if (o_check_po !== 64'h0123_4567_89AB_CDEF)
      $display("FAIL post_reset_po: got %h expected 0123456789abcdef", o_check_po); else passed++;
  endtask

  task automatic test_back_to_back;
    bus.Data  = 64'h1234_5678_9ABC_DEF0;
    bus.Start = 1'b1;
    tick();
    observe(134, 0, 1'b1);
    total++; if (o_load_first !== 1 || o_load_start2 !== 68)
      $display("FAIL b2b_period: got starts at %0d,%0d expected 1,68", o_load_first, o_load_start2); else passed++;
    total++; if (o_done !== 2 || o_done_first !== 66 || o_done_last !== 133)
      $display("FAIL b2b_done: got n=%0d at %0d,%0d expected n=2 at 66,133",
               o_done, o_done_first, o_done_last); else passed++;
    total++; if (o_err_done !== 1'b0) $display("FAIL b2b_err: got %b expected 0", o_err_done); else passed++;
    bus.Start = 1'b0;
    observe(80, 0, 1'b0);
    total++; if (o_done !== 1) $display("FAIL b2b_drain: got %0d expected 1", o_done); else passed++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_clear();
    test_stuck();
    test_priority();
    test_reset_mid_shift();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mask_load_ctrl.md
MASK_LOAD_CTRL -- requirements
Module: mask_load_ctrl

Interface
REQ-001 SHALL have parameter LEN, default 64: length in bits of the serial-in/parallel-out mask register it drives.
REQ-002 SHALL have parameter CW, default 7: width of the shift counter; it shall be at least clog2(LEN)+1.
REQ-003 SHALL have port Clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port Reset, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port Start, input, 1: request to load Data into the mask register; sampled only in IDLE.
REQ-006 SHALL have port Clear, input, 1: request to zero the mask register; sampled only in IDLE.
REQ-007 SHALL have port Data, input, LEN: mask value to load; captured on the accepting edge.
REQ-008 SHALL have port Po, input, LEN: parallel readback from the mask register.
REQ-009 SHALL have port Load, output, 1: shift-enable to the mask register.
REQ-010 SHALL have port Si, output, 1: serial data to the mask register.
REQ-011 SHALL have port ClrOut, output, 1: synchronous reset to the mask register.
REQ-012 SHALL have port Busy, output, 1: high while an operation is in progress.
REQ-013 SHALL have port Done, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port Err, output, 1: readback mismatch flag for the last operation.

Function
REQ-015 SHALL implement the states IDLE, CLEAR, SHIFT, CHECK and DONE.
REQ-016 In IDLE, Clear=1 SHALL load the shadow register with 0, clear Err, and move to CLEAR; Clear SHALL take priority when Start and Clear are both high.
REQ-017 In IDLE, Start=1 with Clear=0 SHALL capture Data into the shadow register, zero the counter, clear Err, and move to SHIFT.
REQ-018 In every state other than IDLE, Start and Clear SHALL be ignored, with no queuing.
REQ-019 CLEAR SHALL last 1 cycle with ClrOut=1 and then move to CHECK.
REQ-020 SHIFT SHALL last exactly LEN cycles.
- Load=1 and Si=shadow[LEN-1] in each of those cycles.
- At each edge the shadow rotates left by 1 and the counter increments.
- When the counter reaches LEN-1, the next state is CHECK.
REQ-021 MSB-first order SHALL leave Data[k] in Po[k] after the last SHIFT edge, and the shadow SHALL again equal Data at that point.
REQ-022 CHECK SHALL last 1 cycle with Load=0; it registers Err <= (Po != shadow) and then moves to DONE.
REQ-023 DONE SHALL last 1 cycle with Done=1 and Busy=0 and then return to IDLE.
REQ-024 Err SHALL be valid from DONE onward and hold until the next accepted Start or Clear.
REQ-025 Busy SHALL be 1 in CLEAR, SHIFT and CHECK, and 0 in IDLE and DONE.
REQ-026 Si SHALL be 0 whenever Load=0.
REQ-027 Load and ClrOut SHALL never both be 1.
REQ-028 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs.
REQ-029 Load latency SHALL be as follows, with Start accepted at edge 0:
- Load high at cycles 1..LEN.
- CHECK at cycle LEN+1.
- Done at cycle LEN+2.
REQ-030 Clear latency SHALL be: ClrOut at cycle 1, CHECK at cycle 2, Done at cycle 3.

Reset
REQ-031 Reset=0 SHALL immediately force IDLE, asynchronously, in any state including mid-SHIFT.
REQ-032 While Reset=0, the shadow register, counter, Load, Si, ClrOut, Busy, Done and Err SHALL all be 0.
REQ-033 Reset SHALL NOT drive ClrOut, so a partially shifted mask register keeps its contents; software reloads it.
REQ-034 After Reset deasserts, the first rising edge with Start or Clear high SHALL be accepted normally.

Verification
REQ-035 Bench SHALL cover basic load with LEN=64 and Data=64'h8000_0000_0000_0001 plus a behavioural model of the shift register:
- Stimulus: Start.
- Required response: Load high for exactly 64 cycles, Si=1 on shift cycles 1 and 64 only, Po=Data at CHECK, Done at cycle 66, Err=0.
REQ-036 Bench SHALL cover clear, starting with the model holding 64'hFFFF_FFFF_FFFF_FFFF:
- Stimulus: Clear.
- Required response: ClrOut for 1 cycle at cycle 1, Load never high, Done at cycle 3, Err=0, Po=0.
REQ-037 Bench SHALL cover a stuck readback bit:
- Stimulus: Po[5] forced to 0, then Start with Data all ones.
- Required response: Err=1 from DONE onward, held through idle cycles, cleared on the edge that accepts the next Start.
REQ-038 Bench SHALL cover command priority and non-queuing:
- Stimulus 1: Start and Clear high in the same IDLE cycle.
- Required response 1: CLEAR path taken and no SHIFT.
- Stimulus 2: Start pulsed again at SHIFT cycle 10.
- Required response 2: ignored; exactly one Done.
REQ-039 Bench SHALL cover reset mid-shift:
- Stimulus: Reset=0 asynchronously at SHIFT cycle 30.
- Required response: Load, Si, Busy and Done go to 0 without waiting for an edge; after release, Start with Data=64'h0123_4567_89AB_CDEF completes with Err=0.
REQ-040 Bench SHALL cover Start held high continuously:
- Required response: operations run back to back, with each new load accepted on the first IDLE cycle after DONE, a period of LEN+3 cycles.
